// File: rtl/svf_seq_pkg.sv
// Shared types and constants for the time-multiplexed state-variable filter sequencer.
package svf_seq_pkg;

    localparam int SAMPLE_W = 16;
    localparam int F_SHIFT  = 15;
    localparam int Q_SHIFT  = 14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MQ,
        S_MF,
        S_HP,
        S_BP,
        S_DONE
    } state_t;

    function automatic int slot_of(input int v);
        return v * SAMPLE_W;
    endfunction

endpackage

// File: rtl/svf_mul16.sv
// Registered signed 16x16 -> 32 multiplier; one cycle of latency, one SB_MAC16 worth of logic.
module svf_mul16 (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p
);

    logic signed [31:0] p_d;
    logic signed [31:0] p_q;

    always_comb begin
        p_d = a * b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;

endmodule

// File: rtl/svf_voice_sequencer.sv
// Chamberlin SVF for VOICES voices sharing one registered multiplier; fixed 4-cycle
// schedule per voice, all results published together with a one-cycle out_valid.
module svf_voice_sequencer
    import svf_seq_pkg::*;
#(
    parameter int VOICES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sample_stb,
    input  logic [SAMPLE_W*VOICES-1:0]   in_data,
    input  logic [SAMPLE_W*VOICES-1:0]   f_coef,
    input  logic [SAMPLE_W*VOICES-1:0]   q1_coef,
    input  logic [VOICES-1:0]            voice_en,
    input  logic                         clr_overrun,
    output logic [SAMPLE_W*VOICES-1:0]   lp_out,
    output logic [SAMPLE_W*VOICES-1:0]   bp_out,
    output logic [SAMPLE_W*VOICES-1:0]   hp_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam int LW = SAMPLE_W * VOICES;

    state_t state_q, state_d;
    logic [VW-1:0] v_q, v_d;

    logic [LW-1:0] in_snap_q, in_snap_d;
    logic [LW-1:0] f_snap_q, f_snap_d;
    logic [LW-1:0] q1_snap_q, q1_snap_d;
    logic [VOICES-1:0] en_snap_q, en_snap_d;

    logic signed [15:0] lp_q [VOICES];
    logic signed [15:0] lp_d [VOICES];
    logic signed [15:0] bp_q [VOICES];
    logic signed [15:0] bp_d [VOICES];
    logic signed [15:0] hp_q [VOICES];
    logic signed [15:0] hp_d [VOICES];
    logic signed [15:0] qbp_q, qbp_d;

    logic [LW-1:0] lp_out_q, lp_out_d;
    logic [LW-1:0] bp_out_q, bp_out_d;
    logic [LW-1:0] hp_out_q, hp_out_d;
    logic out_valid_q, out_valid_d;
    logic overrun_q, overrun_d;

    logic signed [15:0] mul_a, mul_b;
    logic signed [31:0] prod;
    logic signed [15:0] prod_f, prod_qs;
    logic signed [15:0] cur_in, cur_f, cur_q1;
    logic signed [15:0] lp_n, hp_n;
    int base;

    svf_mul16 u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (mul_a),
        .b     (mul_b),
        .p     (prod)
    );

    // Bit slices equal (prod >>> shift)[15:0]; the upper bits are discarded by the wrap.
    assign prod_f  = prod[F_SHIFT +: SAMPLE_W];
    assign prod_qs = prod[Q_SHIFT +: SAMPLE_W];

    always_comb begin
        base   = slot_of(int'(v_q));
        cur_in = in_snap_q[base +: SAMPLE_W];
        cur_f  = f_snap_q[base +: SAMPLE_W];
        cur_q1 = q1_snap_q[base +: SAMPLE_W];
        lp_n   = lp_q[v_q] + prod_f;
        hp_n   = cur_in - lp_n - qbp_q;
    end

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        in_snap_d   = in_snap_q;
        f_snap_d    = f_snap_q;
        q1_snap_d   = q1_snap_q;
        en_snap_d   = en_snap_q;
        lp_d        = lp_q;
        bp_d        = bp_q;
        hp_d        = hp_q;
        qbp_d       = qbp_q;
        lp_out_d    = lp_out_q;
        bp_out_d    = bp_out_q;
        hp_out_d    = hp_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;
        mul_a       = '0;
        mul_b       = '0;

        // A strobe while busy outranks a simultaneous clear.
        if (clr_overrun) overrun_d = 1'b0;
        if (sample_stb && state_q != S_IDLE) overrun_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sample_stb) begin
                    in_snap_d = in_data;
                    f_snap_d  = f_coef;
                    q1_snap_d = q1_coef;
                    en_snap_d = voice_en;
                    v_d       = '0;
                    state_d   = S_MQ;
                end
            end
            S_MQ: begin
                mul_a   = bp_q[v_q];
                mul_b   = cur_q1;
                state_d = S_MF;
            end
            S_MF: begin
                qbp_d   = prod_qs;
                mul_a   = bp_q[v_q];
                mul_b   = cur_f;
                state_d = S_HP;
            end
            S_HP: begin
                lp_d[v_q] = lp_n;
                hp_d[v_q] = hp_n;
                mul_a     = hp_n;
                mul_b     = cur_f;
                state_d   = S_BP;
            end
            S_BP: begin
                if (en_snap_q[v_q]) begin
                    bp_d[v_q] = bp_q[v_q] + prod_f;
                end else begin
                    lp_d[v_q] = '0;
                    bp_d[v_q] = '0;
                    hp_d[v_q] = '0;
                end
                if (v_q == VW'(VOICES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    v_d     = v_q + VW'(1);
                    state_d = S_MQ;
                end
            end
            S_DONE: begin
                for (int i = 0; i < VOICES; i++) begin
                    lp_out_d[slot_of(i) +: SAMPLE_W] = lp_q[i];
                    bp_out_d[slot_of(i) +: SAMPLE_W] = bp_q[i];
                    hp_out_d[slot_of(i) +: SAMPLE_W] = hp_q[i];
                end
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            v_q         <= '0;
            in_snap_q   <= '0;
            f_snap_q    <= '0;
            q1_snap_q   <= '0;
            en_snap_q   <= '0;
            qbp_q       <= '0;
            lp_out_q    <= '0;
            bp_out_q    <= '0;
            hp_out_q    <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                lp_q[i] <= '0;
                bp_q[i] <= '0;
                hp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            in_snap_q   <= in_snap_d;
            f_snap_q    <= f_snap_d;
            q1_snap_q   <= q1_snap_d;
            en_snap_q   <= en_snap_d;
            qbp_q       <= qbp_d;
            lp_out_q    <= lp_out_d;
            bp_out_q    <= bp_out_d;
            hp_out_q    <= hp_out_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            for (int i = 0; i < VOICES; i++) begin
                lp_q[i] <= lp_d[i];
                bp_q[i] <= bp_d[i];
                hp_q[i] <= hp_d[i];
            end
        end
    end

    assign lp_out    = lp_out_q;
    assign bp_out    = bp_out_q;
    assign hp_out    = hp_out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_svf_voice_sequencer.sv
// Bench for svf_voice_sequencer: per-sample arithmetic model, cycle-level timing model,
// per-cycle comparison of every output, and hand-computed anchor values.
module tb_svf_voice_sequencer;

    localparam int V  = 4;
    localparam int LW = 16 * V;
    localparam int FW = 3 * LW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_stb = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [LW-1:0] in_data = '0;
    logic [LW-1:0] f_coef = '0;
    logic [LW-1:0] q1_coef = '0;
    logic [V-1:0]  voice_en = '0;
    logic [LW-1:0] lp_out, bp_out, hp_out;
    logic          out_valid, busy, overrun;

    svf_voice_sequencer #(.VOICES(V)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_stb  (sample_stb),
        .in_data     (in_data),
        .f_coef      (f_coef),
        .q1_coef     (q1_coef),
        .voice_en    (voice_en),
        .clr_overrun (clr_overrun),
        .lp_out      (lp_out),
        .bp_out      (bp_out),
        .hp_out      (hp_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // ---------------- model state ----------------
    shortint m_lp [V];
    shortint m_bp [V];
    logic [FW-1:0] exp_q[$];
    logic [LW-1:0] cur_lp = '0, cur_bp = '0, cur_hp = '0;
    int  cyc = 0;
    int  bs = 1, be = 0, vc = -1;
    bit  ovr_m = 1'b0;
    bit  busy_now;
    logic [FW-1:0] frame;

    initial begin
        for (int i = 0; i < V; i++) begin
            m_lp[i] = 0;
            m_bp[i] = 0;
        end
    end

    function automatic logic [15:0] lane(input logic [LW-1:0] x, input int v);
        return x[16*v +: 16];
    endfunction

    // One sample of the filter for every voice, straight from the update equations.
    task automatic model_accept(output logic [FW-1:0] fr);
        logic [LW-1:0] lv, bv, hv;
        shortint x, f, q, qbp, lp, hp, bp;
        lv = '0; bv = '0; hv = '0;
        for (int v = 0; v < V; v++) begin
            x = shortint'(lane(in_data, v));
            f = shortint'(lane(f_coef, v));
            q = shortint'(lane(q1_coef, v));
            if (!voice_en[v]) begin
                lp = 0; bp = 0; hp = 0;
            end else begin
                qbp = shortint'((int'(m_bp[v]) * int'(q)) >>> 14);
                lp  = shortint'(int'(m_lp[v]) + int'(shortint'((int'(m_bp[v]) * int'(f)) >>> 15)));
                hp  = shortint'(int'(x) - int'(lp) - int'(qbp));
                bp  = shortint'(int'(m_bp[v]) + int'(shortint'((int'(hp) * int'(f)) >>> 15)));
            end
            m_lp[v] = lp;
            m_bp[v] = bp;
            lv[16*v +: 16] = lp;
            bv[16*v +: 16] = bp;
            hv[16*v +: 16] = hp;
        end
        fr = {lv, bv, hv};
    endtask

    task automatic model_reset();
        for (int i = 0; i < V; i++) begin
            m_lp[i] = 0;
            m_bp[i] = 0;
        end
        exp_q.delete();
        cur_lp = '0; cur_bp = '0; cur_hp = '0;
        bs = 1; be = 0; vc = -1;
        ovr_m = 1'b0;
    endtask

    // Timing model: accepted strobe in cycle k -> busy k+1..k+4V+1, out_valid in k+4V+2.
    always @(posedge clk) begin
        if (rst_n) begin
            busy_now = (cyc >= bs && cyc <= be);
            if (sample_stb && busy_now) ovr_m = 1'b1;
            else if (clr_overrun) ovr_m = 1'b0;
            if (sample_stb && !busy_now) begin
                model_accept(frame);
                exp_q.push_back(frame);
                bs = cyc + 1;
                be = cyc + 4 * V + 1;
                vc = cyc + 4 * V + 2;
            end
            cyc++;
            if (cyc == vc && exp_q.size() > 0) begin
                frame = exp_q.pop_front();
                {cur_lp, cur_bp, cur_hp} = frame;
            end
        end else begin
            cyc++;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0b exp=%0b", name, cyc, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc,
                     $signed(act), $signed(exp));
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk1("busy_in_reset", busy, 1'b0);
            chk1("valid_in_reset", out_valid, 1'b0);
        end else begin
            chk1("busy", busy, (cyc >= bs && cyc <= be));
            chk1("out_valid", out_valid, (cyc == vc));
            chk1("overrun", overrun, ovr_m);
            chkv("lp_out", lp_out, cur_lp);
            chkv("bp_out", bp_out, cur_bp);
            chkv("hp_out", hp_out, cur_hp);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_all(input logic [15:0] x, input logic [15:0] f, input logic [15:0] q,
                           input logic [V-1:0] en);
        for (int v = 0; v < V; v++) begin
            in_data[16*v +: 16] = x;
            f_coef[16*v +: 16]  = f;
            q1_coef[16*v +: 16] = q;
        end
        voice_en = en;
    endtask

    // Called at a falling edge; returns at the falling edge of the following cycle.
    task automatic do_strobe();
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    // Strobe, then wait until the cycle where out_valid must be high.
    task automatic do_sample();
        do_strobe();
        repeat (4 * V + 1) @(negedge clk);
        chk1("valid_at_18", out_valid, 1'b1);
    endtask

    task automatic test1_stim();
        set_all(16'd0, 16'h2000, 16'h4000, '1);
        in_data[15:0] = 16'd16384;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_overrun", overrun, 1'b0);
        chkv("reset_lp", lp_out, '0);

        // Two samples of a single excited voice, values worked by hand.
        test1_stim();
        do_sample();
        chk16("s1_lp0", lane(lp_out, 0), 16'd0);
        chk16("s1_hp0", lane(hp_out, 0), 16'd16384);
        chk16("s1_bp0", lane(bp_out, 0), 16'd4096);
        do_sample();
        chk16("s2_lp0", lane(lp_out, 0), 16'd1024);
        chk16("s2_hp0", lane(hp_out, 0), 16'd11264);
        chk16("s2_bp0", lane(bp_out, 0), 16'd6912);
        chk16("s2_lp1", lane(lp_out, 1), 16'd0);
        chk16("s2_bp3", lane(bp_out, 3), 16'd0);
        repeat (2) @(negedge clk);

        // Voice 1 disabled: its lane is flushed each sample, timing unchanged.
        set_all(16'd8000, 16'd8000, 16'd8000, 4'b1101);
        for (int s = 0; s < 3; s++) begin
            do_sample();
            chk16("dis_lp1", lane(lp_out, 1), 16'd0);
            chk16("dis_bp1", lane(bp_out, 1), 16'd0);
            chk16("dis_hp1", lane(hp_out, 1), 16'd0);
        end
        repeat (3) @(negedge clk);

        // Strobes every 10 cycles: every other one lands while busy.
        do_strobe();
        repeat (9) @(negedge clk);
        do_strobe();
        chk1("ovr_after_2nd", overrun, 1'b1);
        repeat (9) @(negedge clk);
        do_strobe();
        repeat (9) @(negedge clk);
        do_strobe();
        repeat (20) @(negedge clk);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        chk1("ovr_cleared", overrun, 1'b0);
        repeat (2) @(negedge clk);

        // Reset asserted in cycle k+7 of a sequence.
        test1_stim();
        do_strobe();
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk1("async_busy_drop", busy, 1'b0);
        chkv("async_lp_clear", lp_out, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        chk1("no_valid_after_rst", out_valid, 1'b0);
        do_sample();
        chk16("rst_lp0", lane(lp_out, 0), 16'd0);
        chk16("rst_hp0", lane(hp_out, 0), 16'd16384);
        chk16("rst_bp0", lane(bp_out, 0), 16'd4096);

        // Random samples, full 16-bit operands so wrapping is exercised.
        for (int n = 0; n < 1000; n++) begin
            for (int v = 0; v < V; v++) begin
                in_data[16*v +: 16] = 16'($urandom);
                f_coef[16*v +: 16]  = 16'($urandom);
                q1_coef[16*v +: 16] = 16'($urandom);
            end
            voice_en = ($urandom_range(0, 7) == 0) ? V'($urandom) : '1;
            do_strobe();
            repeat ($urandom_range(17, 22)) @(negedge clk);
        end
        repeat (25) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
